ring_input_buffer: RTL
======================

Name: ring_input_buffer

Overview:
- Write side of the ring router's per-port packet buffers. Accepts transit packets from the upstream ring link into a high-priority buffer and packets from the local core into a low-priority buffer.
- Stamps injected packets with an age timestamp and computes 2-bit route info per slot.
- Presents both buffer arrays to the switch allocator and frees slots on the allocator's grant.
- Ejects transit packets addressed to this node to the local core and drives the upstream stall.

Parameters:
- NODE_ID, 16'd0, this router's ring node id, compared against the packet destination field.
- OUT_PORT, 2'b01, route code for "forward on ring"; must match the allocator's OUT_PORT.
- PACKET_SIZE, 49, packet width; bit 48 = valid, [47:32] = timestamp, [31:16] = source id, [15:0] = destination id.
- BUFFER_SIZE, 4, slots per priority buffer; only 4 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_packet  in  PACKET_SIZE  upstream ring packet; meaningful only when bit 48 = 1
- stall_upstream  out  1  registered; upstream must hold off the next packet
- inject_packet  in  PACKET_SIZE  local core packet; bits [47:32] are overwritten
- inject_valid  in  1  local injection request
- inject_ready  out  1  a low-buffer slot is free
- buffer_high_prior  out  PACKET_SIZE x BUFFER_SIZE  high buffer contents
- buffer_high_prior_route_info  out  2 x BUFFER_SIZE  per-slot route code
- buffer_low_prior  out  PACKET_SIZE x BUFFER_SIZE  low buffer contents
- buffer_low_prior_route_info  out  2 x BUFFER_SIZE  per-slot route code
- grant_pos  in  16  slot index granted by the allocator
- grant_valid  in  1  grant strobe
- grant_in_high  in  1  1 = grant applies to the high buffer, 0 = low buffer
- eject_packet  out  PACKET_SIZE  packet leaving the ring to the local core
- eject_valid  out  1  eject_packet holds a valid packet
- eject_ready  in  1  local core accepts the ejected packet

Behaviour:
- Reset: all slots, route info, stall_upstream, eject_packet, eject_valid, inject_ready and the age counter are 0. Reset is asynchronous and takes effect mid-operation; all buffered packets are discarded.
- Route code, computed at write time and stored with the slot:
  - destination == NODE_ID gives 2'b00 (eject).
  - Any other destination gives OUT_PORT.
  - An empty slot's route info is 2'b00.
- Age counter: 16-bit, increments every cycle out of reset, wraps 0xFFFF to 0x0000.
- Transit write:
  - If in_packet[48] = 1, the packet is written at the next edge into the lowest-index free high slot (free = bit 48 is 0 at the start of the cycle). The timestamp is preserved.
  - in_packet[48] = 0 is ignored.
- Injection:
  - inject_ready = rst_n && (a low slot is free); it is combinational from current state.
  - On inject_valid && inject_ready, the lowest free low slot receives inject_packet with [48] = 1 and [47:32] = age counter in that cycle.
- Grant: on grant_valid, the slot grant_pos in the buffer selected by grant_in_high is cleared to 0 (packet and route) at the next edge.
  - grant_pos >= BUFFER_SIZE is ignored.
  - A grant on an empty slot has no effect.
- Eject:
  - eject_valid/eject_packet are combinational: the lowest-index high slot with [48] = 1 and route 2'b00.
  - On eject_valid && eject_ready, that slot is cleared at the next edge.
- Simultaneous events:
  - A grant or eject and a write in the same cycle are both applied.
  - A slot freed this cycle is not reused until the next cycle.
  - A grant and an eject on the same slot clear it once.
- stall_upstream: registered; equals 1 when the high buffer has fewer than 2 free slots after this cycle's writes and clears. The spare slot covers the one-cycle stall latency.
- Overflow: a transit packet that arrives while all 4 high slots are valid is dropped. See the optional feature.

Optional Feature:
- Macro: RING_IBUF_OVF_DETECT_EN.
- When defined, the block adds two outputs:
  - overflow_err (1 bit, sticky, cleared only by reset): set on a dropped transit packet.
  - drop_count (16 bits): increments on each drop and saturates at 0xFFFF.
- When undefined, these ports are absent and drops are silent.

Test Plan:
- Reset, then check outputs: all buffer outputs 0, inject_ready = 1 one cycle after rst_n rises, stall_upstream = 0, eject_valid = 0.
- Injection at age counter 0x0005: inject_packet dest = 16'h0003, NODE_ID = 0 → buffer_low_prior[0] = {1'b1, 16'h0005, src, 16'h0003}, route[0] = 2'b01. Four injections fill the buffer → inject_ready = 0. Grant pos 2, low → slot 2 cleared, inject_ready = 1.
- Transit forwarding and stall: 3 consecutive transit packets, dest 16'h0007 → high slots 0..2 filled with route 01. stall_upstream = 1 the cycle after the 3rd write. Grant pos 1, high → stall_upstream drops to 0.
- Eject: transit packet dest = NODE_ID → eject_valid = 1 with that packet. eject_ready = 1 → slot cleared and eject_valid = 0 next cycle. eject_ready held 0 → packet held, and a grant on the same slot clears it.
- Simultaneous events: grant on slot 0 and a new write while slot 0 is the only freed slot → write lands in the next free slot, not slot 0. Age counter at 0xFFFF followed by an injection the next cycle → timestamp 0x0000.
- Overflow, with RING_IBUF_OVF_DETECT_EN: fill 4 high slots, send a 5th transit packet → packet dropped, overflow_err = 1, drop_count = 1. Send 2 more → drop_count = 3. Without the macro, the same drop occurs silently.

Source files
------------

// File: rtl/ring_input_buffer.sv
// ring_input_buffer: write side of a ring router port's packet buffers.
// Transit packets from the upstream link land in the high-priority buffer and
// local injections land in the low-priority buffer, stamped with the age
// counter. Each slot carries a 2-bit route code computed when it is written.
// The switch allocator frees slots by grant. Transit packets addressed to this
// node are ejected to the local core.
// Optional feature: define RING_IBUF_OVF_DETECT_EN to add the overflow_err and
// drop_count outputs. When it is undefined, dropped transit packets are silent.
module ring_input_buffer #(
  parameter logic [15:0] NODE_ID     = 16'd0,
  parameter logic [1:0]  OUT_PORT    = 2'b01,
  parameter int unsigned PACKET_SIZE = 49,
  parameter int unsigned BUFFER_SIZE = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  // upstream ring link
  input  logic [PACKET_SIZE-1:0]                  in_packet,
  output logic                                    stall_upstream,
  // local injection
  input  logic [PACKET_SIZE-1:0]                  inject_packet,
  input  logic                                    inject_valid,
  output logic                                    inject_ready,
  // buffer view for the switch allocator
  output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_high_prior,
  output logic [BUFFER_SIZE-1:0][1:0]             buffer_high_prior_route_info,
  output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_low_prior,
  output logic [BUFFER_SIZE-1:0][1:0]             buffer_low_prior_route_info,
  // allocator grant
  input  logic [15:0]                             grant_pos,
  input  logic                                    grant_valid,
  input  logic                                    grant_in_high,
  // ejection to the local core
  output logic [PACKET_SIZE-1:0]                  eject_packet,
  output logic                                    eject_valid,
  input  logic                                    eject_ready
`ifdef RING_IBUF_OVF_DETECT_EN
  ,
  output logic                                    overflow_err,
  output logic [15:0]                             drop_count
`endif
);

  // Packet layout: valid at the top, then the 16-bit timestamp, source id and
  // destination id.
  localparam int unsigned ValidBit = PACKET_SIZE - 1;
  localparam int unsigned TsHi     = PACKET_SIZE - 2;
  localparam int unsigned TsLo     = PACKET_SIZE - 17;
  localparam int unsigned IdxW     = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int unsigned CntW     = IdxW + 1;

  localparam logic [1:0] RouteEject = 2'b00;

  // Route code for a packet being written into a slot.
  function automatic logic [1:0] route_of(input logic [PACKET_SIZE-1:0] pkt);
    return (pkt[15:0] == NODE_ID) ? RouteEject : OUT_PORT;
  endfunction

  // Slot storage
  logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] high_q, high_d;
  logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] low_q, low_d;
  logic [BUFFER_SIZE-1:0][1:0]             high_route_q, high_route_d;
  logic [BUFFER_SIZE-1:0][1:0]             low_route_q, low_route_d;
  logic [15:0]                             age_q, age_d;
  logic                                    stall_q, stall_d;

  // Slot search results, all taken from the state at the start of the cycle
  logic            high_free_found;
  logic [IdxW-1:0] high_free_idx;
  logic            low_free_found;
  logic [IdxW-1:0] low_free_idx;
  logic            eject_found;
  logic [IdxW-1:0] eject_idx;

  // Per-cycle events
  logic                   transit_wr;
  logic                   inject_wr;
  logic                   eject_clr;
  logic                   grant_in_range;
  logic [IdxW-1:0]        grant_idx;
  logic [PACKET_SIZE-1:0] inject_stamped;
  logic [CntW-1:0]        high_free_after;

  // Lowest-index free slot in each buffer and the lowest ejectable high slot.
  always_comb begin
    high_free_found = 1'b0;
    high_free_idx   = '0;
    low_free_found  = 1'b0;
    low_free_idx    = '0;
    eject_found     = 1'b0;
    eject_idx       = '0;
    // Scan downwards so the lowest matching index is the last one recorded.
    for (int i = int'(BUFFER_SIZE) - 1; i >= 0; i--) begin
      if (!high_q[i][ValidBit]) begin
        high_free_found = 1'b1;
        high_free_idx   = IdxW'(i);
      end
      if (!low_q[i][ValidBit]) begin
        low_free_found = 1'b1;
        low_free_idx   = IdxW'(i);
      end
      if (high_q[i][ValidBit] && (high_route_q[i] == RouteEject)) begin
        eject_found = 1'b1;
        eject_idx   = IdxW'(i);
      end
    end
  end

  // Decode this cycle's writes, clears and the stamped injection packet.
  always_comb begin
    transit_wr     = in_packet[ValidBit] && high_free_found;
    inject_wr      = inject_valid && inject_ready;
    eject_clr      = eject_found && eject_ready;
    grant_in_range = grant_valid && (grant_pos < 16'(BUFFER_SIZE));
    grant_idx      = grant_pos[IdxW-1:0];
    inject_stamped                = inject_packet;
    inject_stamped[ValidBit]      = 1'b1;
    inject_stamped[TsHi:TsLo]     = age_q;
  end

  // Next slot state: clears first, then writes into slots free at cycle start.
  // A grant on an empty slot that is being written this cycle must not erase
  // the write, hence the ordering.
  always_comb begin
    high_d       = high_q;
    low_d        = low_q;
    high_route_d = high_route_q;
    low_route_d  = low_route_q;

    if (grant_in_range) begin
      if (grant_in_high) begin
        high_d[grant_idx]       = '0;
        high_route_d[grant_idx] = 2'b00;
      end else begin
        low_d[grant_idx]        = '0;
        low_route_d[grant_idx]  = 2'b00;
      end
    end

    // A grant on the ejecting slot just clears it a second time, harmlessly.
    if (eject_clr) begin
      high_d[eject_idx]       = '0;
      high_route_d[eject_idx] = 2'b00;
    end

    if (transit_wr) begin
      high_d[high_free_idx]       = in_packet;
      high_route_d[high_free_idx] = route_of(in_packet);
    end

    if (inject_wr) begin
      low_d[low_free_idx]       = inject_stamped;
      low_route_d[low_free_idx] = route_of(inject_stamped);
    end
  end

  // Count free high slots after this cycle; keep one spare for stall latency.
  always_comb begin
    high_free_after = '0;
    for (int i = 0; i < int'(BUFFER_SIZE); i++) begin
      high_free_after = high_free_after + CntW'(!high_d[i][ValidBit]);
    end
    stall_d = (high_free_after < CntW'(2));
    age_d   = age_q + 16'd1;
  end

  // Buffer, route, age and stall registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_q       <= '0;
      low_q        <= '0;
      high_route_q <= '0;
      low_route_q  <= '0;
      age_q        <= '0;
      stall_q      <= 1'b0;
    end else begin
      high_q       <= high_d;
      low_q        <= low_d;
      high_route_q <= high_route_d;
      low_route_q  <= low_route_d;
      age_q        <= age_d;
      stall_q      <= stall_d;
    end
  end

  // Output view of the state.
  always_comb begin
    buffer_high_prior            = high_q;
    buffer_high_prior_route_info = high_route_q;
    buffer_low_prior             = low_q;
    buffer_low_prior_route_info  = low_route_q;
    stall_upstream               = stall_q;
    inject_ready                 = rst_n && low_free_found;
    eject_valid                  = eject_found;
    eject_packet                 = eject_found ? high_q[eject_idx] : '0;
  end

`ifdef RING_IBUF_OVF_DETECT_EN
  logic        drop;
  logic        ovf_q;
  logic [15:0] drop_q;

  // A transit packet with no free high slot at cycle start is lost.
  always_comb begin
    drop = in_packet[ValidBit] && !high_free_found;
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign overflow_err = ovf_q;
  assign drop_count   = drop_q;
`endif

endmodule
